// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: frame geometry,
// line levels and the receiver state encoding.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned UART_IDX_W     = $clog2(UART_DATA_BITS);

    localparam logic UART_START_LVL = 1'b0;
    localparam logic UART_STOP_LVL  = 1'b1;
    localparam logic UART_IDLE_LVL  = 1'b1;

    typedef enum logic [2:0] {
        WAIT_HIGH,
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter for the UART receiver. Counts elapsed clocks within a bit
// period and strobes at the sample point and at the half-bit point.
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic realign_i,
    output logic sample_o,
    output logic mid_o
);

    localparam int unsigned    TW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0]  LOAD_VAL = (CLKS_PER_BIT > 1) ? TW'(1) : TW'(0);
    localparam logic [TW-1:0]  WRAP_VAL = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]  HALF_VAL = TW'(CLKS_PER_BIT / 2);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // The cycle that triggers a clear/realign counts as tick 0 of the new period,
    // so the counter is loaded with 1; with one clock per bit it stays at 0.
    always_comb begin
        cnt_d = cnt_q + TW'(1);
        if (clear_i || realign_i) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q == WRAP_VAL) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sample_o = (cnt_q == '0);
    assign mid_o    = (cnt_q == HALF_VAL);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: deserialises start/8-data/stop frames (MSB first) from rx and
// presents each byte on a valid/ready port, flagging framing errors and overruns.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic                      CLK,
    input  logic                      ASYNCRESET,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data,
    output logic                      valid,
    input  logic                      ready,
    output logic                      frame_err,
    output logic                      overrun
);

    localparam logic [UART_IDX_W-1:0] IDX_LAST = UART_IDX_W'(UART_DATA_BITS - 1);

    uart_rx_state_e            state_q;
    logic [UART_IDX_W-1:0]     bit_idx_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic [UART_DATA_BITS-1:0] data_q;
    logic                      valid_q;
    logic                      frame_err_q;
    logic                      overrun_q;

    logic tmr_clear;
    logic tmr_realign;
    logic tmr_sample;
    logic tmr_mid;

    assign tmr_clear   = (state_q == IDLE)  && (rx == UART_START_LVL);
    assign tmr_realign = (state_q == START) && tmr_mid && (rx == UART_START_LVL);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk_i    (CLK),
        .rst_ni   (ASYNCRESET),
        .clear_i  (tmr_clear),
        .realign_i(tmr_realign),
        .sample_o (tmr_sample),
        .mid_o    (tmr_mid)
    );

    always_ff @(posedge CLK or negedge ASYNCRESET) begin
        if (!ASYNCRESET) begin
            state_q     <= WAIT_HIGH;
            bit_idx_q   <= IDX_LAST;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            if (valid_q && ready) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                WAIT_HIGH: begin
                    if (rx == UART_IDLE_LVL) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (rx == UART_START_LVL) begin
                        bit_idx_q <= IDX_LAST;
                        state_q   <= (CLKS_PER_BIT > 1) ? START : DATA;
                    end
                end
                START: begin
                    if (tmr_mid) begin
                        state_q <= (rx == UART_START_LVL) ? DATA : IDLE;
                    end
                end
                DATA: begin
                    if (tmr_sample) begin
                        shift_q <= {shift_q[UART_DATA_BITS-2:0], rx};
                        if (bit_idx_q == '0) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q - UART_IDX_W'(1);
                        end
                    end
                end
                STOP: begin
                    // A held, unconsumed byte wins over the new one; the newcomer is dropped.
                    if (tmr_sample) begin
                        if (rx == UART_STOP_LVL) begin
                            if (!valid_q || ready) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                            state_q <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_HIGH;
                        end
                    end
                end
                default: begin
                    state_q <= WAIT_HIGH;
                end
            endcase
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
